clk_period_meter: RTL and testbench

Measures a slow clock or strobe produced elsewhere in the design, such as a divided clock, using the fast system clock. It synchronises the input and detects its edges. It reports period and high time in in_clk cycles, a lock indication for a stable frequency, and a timeout when the input stops toggling. It is the checking end of the clock-division path and is used for on-chip verification of generated clocks.

---
 rtl/clk_period_meter.sv | 164 ++++++++++++++++
 tb/tb_clk_period_meter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures a slow clock or strobe with the fast system clock. sig_in is
//   synchronised, its edges are detected, and the meter reports the period and
//   high time in in_clk cycles. It also flags a stable frequency (locked) and a
//   stopped input (timeout).
//
// Ports
//   in_clk      system clock; all logic is on its rising edge
//   reset       asynchronous active-low reset
//   enable      1 = measure, 0 = return to IDLE (synchronous)
//   sig_in      asynchronous signal under measurement
//   period      last measured period, in in_clk cycles
//   high_time   high time of the last measured period, in in_clk cycles
//   meas_valid  one-cycle pulse when period/high_time update
//   locked      LOCK_COUNT consecutive periods within TOL of their predecessor
//   timeout     no rising edge for TIMEOUT cycles while measuring
module clk_period_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 50000,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TOL         = 1
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    STALL
  } state_t;

  localparam int unsigned       MATCH_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  TOL_C     = CNT_W'(TOL);
  localparam logic [MATCH_W-1:0] LOCK_C   = MATCH_W'(LOCK_COUNT);

  state_t               state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 prev_q;
  logic                 s;
  logic                 rise;
  logic                 fall;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     high_shadow;
  logic [CNT_W-1:0]     diff;
  logic                 in_tol;
  logic [MATCH_W-1:0]   match_cnt;
  logic [MATCH_W-1:0]   match_inc;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  // Absolute difference between the period being published (cnt at a rise)
  // and the previously published period still held on the output.
  always_comb begin
    diff      = (cnt >= period) ? (cnt - period) : (period - cnt);
    in_tol    = (diff <= TOL_C);
    match_inc = (match_cnt == LOCK_C) ? match_cnt : match_cnt + MATCH_W'(1);
  end

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= s;
      if (rise) begin
        cnt <= CNT_W'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      period      <= '0;
      high_time   <= '0;
      high_shadow <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
      match_cnt   <= '0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        locked    <= 1'b0;
        timeout   <= 1'b0;
        match_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) state <= ARMED;
          end
          ARMED: begin
            if (rise) begin
              // First complete period: publish but there is nothing to
              // compare against yet.
              period     <= cnt;
              high_time  <= high_shadow;
              meas_valid <= 1'b1;
              match_cnt  <= '0;
              locked     <= 1'b0;
              state      <= RUN;
            end else begin
              if (fall) high_shadow <= cnt;
              if (cnt == TIMEOUT_C) begin
                state     <= STALL;
                timeout   <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
              end
            end
          end
          RUN: begin
            if (rise) begin
              period     <= cnt;
              high_time  <= high_shadow;
              meas_valid <= 1'b1;
              if (in_tol) begin
                match_cnt <= match_inc;
                if (match_inc == LOCK_C) locked <= 1'b1;
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
              end
            end else begin
              if (fall) high_shadow <= cnt;
              if (cnt == TIMEOUT_C) begin
                state     <= STALL;
                timeout   <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
              end
            end
          end
          STALL: begin
            if (rise) begin
              state   <= ARMED;
              timeout <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter. sig_in is built from (high, low) pulse
// segments; an event-level model predicts every publish, timeout set and
// timeout clear (kind, cycle and values) into a queue that a monitor drains.
module tb_clk_period_meter;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 40;
  localparam int LOCK_COUNT  = 4;
  localparam int TOL         = 1;
  localparam int LAT         = SYNC_STAGES + 1;

  localparam int EV_PUB = 0;
  localparam int EV_SET = 1;
  localparam int EV_CLR = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_STALL = 3;

  typedef struct {
    int kind;
    int cyc;
    int per;
    int ht;
    int lk;
  } ev_t;

  logic             in_clk = 1'b0;
  logic             reset  = 1'b0;
  logic             enable = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  ev_t exp_q[$];
  int  cyc   = 0;
  int  n_vec = 0;
  int  n_err = 0;

  // reference model state
  int m_mode   = M_IDLE;
  int m_match  = 0;
  int m_locked = 0;
  int m_last   = 0;
  int m_prev_p = 0;
  int m_prev_h = 0;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT),
    .LOCK_COUNT (LOCK_COUNT),
    .TOL        (TOL)
  ) dut (
    .in_clk    (in_clk),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int p, input int h, input int l);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.per  = p;
    e.ht   = h;
    e.lk   = l;
    exp_q.push_back(e);
  endtask

  // Called at the cycle sig_in is driven high; n is that cycle number.
  // Events become visible LAT cycles later.
  task automatic model_rise(input int hi, input int lo, input int n);
    int p;
    int d;
    case (m_mode)
      M_IDLE: m_mode = M_ARMED;
      M_ARMED: begin
        m_match  = 0;
        m_locked = 0;
        push(EV_PUB, n + LAT, m_prev_p, m_prev_h, m_locked);
        m_last = m_prev_p;
        m_mode = M_RUN;
      end
      M_RUN: begin
        d = (m_prev_p > m_last) ? m_prev_p - m_last : m_last - m_prev_p;
        if (d <= TOL) begin
          if (m_match < LOCK_COUNT) m_match++;
          m_locked = (m_match == LOCK_COUNT) ? 1 : 0;
        end else begin
          m_match  = 0;
          m_locked = 0;
        end
        push(EV_PUB, n + LAT, m_prev_p, m_prev_h, m_locked);
        m_last = m_prev_p;
      end
      default: begin
        push(EV_CLR, n + LAT, 0, 0, 0);
        m_mode = M_ARMED;
      end
    endcase
    p = hi + lo;
    if ((m_mode == M_ARMED || m_mode == M_RUN) && p > TIMEOUT) begin
      m_mode   = M_STALL;
      m_match  = 0;
      m_locked = 0;
      push(EV_SET, n + LAT + TIMEOUT, 0, 0, 0);
    end
    m_prev_p = p;
    m_prev_h = hi;
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (kind == EV_PUB) begin
        chk("period", period, e.per);
        chk("high_time", high_time, e.ht);
        chk("locked_at_publish", locked, e.lk);
      end else if (kind == EV_SET) begin
        chk("locked_at_timeout", locked, e.lk);
      end
    end
  endtask

  // Monitor: sample away from the active edge.
  initial begin
    logic to_q;
    to_q = 1'b0;
    forever begin
      @(negedge in_clk);
      if (meas_valid) observe(EV_PUB);
      if (timeout && !to_q) observe(EV_SET);
      if (!timeout && to_q) observe(EV_CLR);
      to_q = timeout;
    end
  end

  // Entered and left at posedge+1. Optionally drops enable for 5 cycles
  // during the low phase (requires hi >= 2, lo >= 7).
  task automatic pulse(input int hi, input int lo, input bit gap);
    sig_in = 1'b1;
    model_rise(hi, lo, cyc);
    repeat (hi) @(posedge in_clk);
    #1 sig_in = 1'b0;
    if (gap) begin
      @(posedge in_clk);
      #1 enable = 1'b0;
      m_mode   = M_IDLE;
      m_match  = 0;
      m_locked = 0;
      repeat (2) @(posedge in_clk);
      #1;
      chk("locked_after_disable", locked, m_locked);
      chk("timeout_after_disable", timeout, 0);
      repeat (3) @(posedge in_clk);
      #1 enable = 1'b1;
      repeat (lo - 6) @(posedge in_clk);
      #1;
    end else begin
      repeat (lo) @(posedge in_clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high_time"}, high_time, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic reset_mid();
    chk("locked_before_reset", locked, m_locked);
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    m_mode   = M_IDLE;
    m_match  = 0;
    m_locked = 0;
    @(posedge in_clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int jit[14] = '{8, 9, 8, 7, 8, 9, 8, 12, 8, 8, 8, 8, 8, 8};
    int hi;
    int lo;
    repeat (3) @(posedge in_clk);
    #1;
    check_reset_outputs("reset");
    reset  = 1'b1;
    enable = 1'b1;
    @(posedge in_clk);
    #1;

    // divide-by-8, phase aligned
    repeat (8) pulse(4, 4, 1'b0);
    // jitter within TOL, then one outlier of 12
    for (int i = 0; i < 14; i++) pulse(4, jit[i] - 4, 1'b0);
    // duty cycles
    repeat (6) pulse(3, 13, 1'b0);
    repeat (6) pulse(1, 9, 1'b0);
    // enable dropped while locked
    repeat (7) pulse(4, 4, 1'b0);
    pulse(4, 12, 1'b1);
    repeat (7) pulse(4, 4, 1'b0);
    // input stops toggling, then restarts
    pulse(4, TIMEOUT + 10, 1'b0);
    repeat (7) pulse(4, 4, 1'b0);
    // period exactly TIMEOUT (no timeout) and TIMEOUT+1 (timeout)
    pulse(4, TIMEOUT - 4, 1'b0);
    pulse(4, 4, 1'b0);
    pulse(4, TIMEOUT - 3, 1'b0);
    repeat (3) pulse(4, 4, 1'b0);
    // reset while locked
    repeat (8) pulse(4, 4, 1'b0);
    reset_mid();
    repeat (4) pulse(4, 4, 1'b0);
    // random segments, occasionally straddling the timeout boundary
    repeat (60) begin
      hi = int'($urandom_range(1, 12));
      if ($urandom_range(0, 9) == 0) lo = TIMEOUT - hi - 1 + int'($urandom_range(0, 3));
      else lo = int'($urandom_range(1, 12));
      pulse(hi, lo, 1'b0);
    end
    pulse(4, TIMEOUT + 10, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge in_clk);
    chk("expected_events_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
